// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 scancode receiver.
//   - prefix bytes (E0 extended, F0 break, E1 pause) and the E0-prefixed
//     fake-shift codes that the extended build suppresses
//   - frame FSM state encodings
//   - key event payload struct and the odd-parity helper
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  // Glitch filter: ps2_clk must be high this many samples, then low as many.
  localparam int unsigned PS2_FILT_LEN = 4;
  localparam int unsigned PS2_HIST_W   = 2 * PS2_FILT_LEN;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       make;
    logic [7:0] code;
    logic       ext;
  } key_event_t;

  // True when data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_if.sv
// ps2_scancode_if: key event bus produced by the scancode receiver.
//   strb : one-cycle pulse qualifying make/code/ext
//   make : 0 = pressed, 1 = released
//   code : scancode with prefixes removed
//   ext  : code was E0-prefixed
//   err  : one-cycle pulse on a discarded frame
interface ps2_scancode_if;

  logic       strb;
  logic       make;
  logic [7:0] code;
  logic       ext;
  logic       err;

  modport master (output strb, make, code, ext, err);
  modport slave  (input  strb, make, code, ext, err);

endinterface

// File: rtl/ps2_scancode_sync.sv
// ps2_sync: double-flop synchronisers for the raw PS/2 lines plus a
// falling-edge detector that only fires after 4 high samples followed by
// 4 low samples of the synchronised clock, rejecting short glitches.
//   clock, reset : system clock, async active-low reset
//   ps2_clk      : raw PS/2 clock line (asynchronous)
//   ps2_dat      : raw PS/2 data line (asynchronous)
//   fall         : one-cycle pulse on a filtered ps2_clk falling edge
//   dat          : synchronised ps2_dat
module ps2_sync
  import ps2_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  localparam logic [PS2_HIST_W-1:0] FALL_PAT =
    {{PS2_FILT_LEN{1'b1}}, {PS2_FILT_LEN{1'b0}}};

  logic [1:0]            clk_meta;
  logic [1:0]            dat_meta;
  logic [PS2_HIST_W-1:0] hist;
  logic [PS2_HIST_W-1:0] hist_nxt;

  assign hist_nxt = {hist[PS2_HIST_W-2:0], clk_meta[1]};
  assign dat      = dat_meta[1];

  // Lines idle high, so the synchronisers and history reset to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_meta <= '1;
      dat_meta <= '1;
      hist     <= '1;
      fall     <= 1'b0;
    end else begin
      clk_meta <= {clk_meta[0], ps2_clk};
      dat_meta <= {dat_meta[0], ps2_dat};
      hist     <= hist_nxt;
      fall     <= (hist_nxt == FALL_PAT);
    end
  end

endmodule

// File: rtl/ps2_scancode.sv
// ps2_scancode: PS/2 keyboard receiver turning raw frames into key events.
//   Parameters : CLK_KHZ (system clock in kHz), TIMEOUT_US (max gap between
//                ps2_clk falling edges inside one frame)
//   clock, reset      : system clock, async active-low reset
//   ps2_clk, ps2_dat  : raw PS/2 lines
//   strb              : one-cycle pulse qualifying make/code/ext
//   make              : 0 = pressed, 1 = released
//   code              : scancode without prefixes
//   ext               : code was E0-prefixed
//   err               : one-cycle pulse on a discarded frame
// Build option PS2_EXTENDED_EN: report E0 on ext and suppress the E0 12 /
// E0 59 fake shifts. Without it ext is 0 and E0 bytes are dropped.
module ps2_scancode
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_KHZ    = 28000,
  parameter int unsigned TIMEOUT_US = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  localparam int unsigned TMO_CYC = CLK_KHZ * TIMEOUT_US / 1000;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic             fall;
  logic             dat;
  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_ok;
  logic             brk;
  logic [TMO_W-1:0] tmo;
  key_event_t       ev;
`ifdef PS2_EXTENDED_EN
  logic             ext_flag;
`endif

  ps2_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .fall    (fall),
    .dat     (dat)
  );

  assign make = ev.make;
  assign code = ev.code;
  assign ext  = ev.ext;

  // Frame FSM, prefix tracking, timeout and registered event outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      brk      <= 1'b0;
      tmo      <= '0;
      strb     <= 1'b0;
      err      <= 1'b0;
      ev       <= '{make: 1'b1, code: 8'h00, ext: 1'b0};
`ifdef PS2_EXTENDED_EN
      ext_flag <= 1'b0;
`endif
    end else begin
      strb <= 1'b0;
      err  <= 1'b0;

      if (state == ST_IDLE || fall) tmo <= '0;
      else                          tmo <= tmo + TMO_W'(1);

      if (state != ST_IDLE && !fall && tmo == TMO_LAST) begin
        // Line went quiet mid-frame: abandon it and any pending prefixes.
        state    <= ST_IDLE;
        err      <= 1'b1;
        brk      <= 1'b0;
`ifdef PS2_EXTENDED_EN
        ext_flag <= 1'b0;
`endif
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            // A high start bit is a false start and is ignored.
            if (!dat) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= odd_ok(shreg, dat);
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!dat || !par_ok) begin
              err      <= 1'b1;
              brk      <= 1'b0;
`ifdef PS2_EXTENDED_EN
              ext_flag <= 1'b0;
`endif
            end else if (shreg == PS2_PFX_BRK) begin
              brk <= 1'b1;
            end else if (shreg == PS2_PFX_EXT) begin
`ifdef PS2_EXTENDED_EN
              ext_flag <= 1'b1;
`endif
            end else if (shreg == PS2_PFX_PAUSE) begin
              brk <= brk;
`ifdef PS2_EXTENDED_EN
            end else if (ext_flag &&
                         (shreg == PS2_FAKE_LSHIFT || shreg == PS2_FAKE_RSHIFT)) begin
              // Fake shift injected around extended keys: swallow it.
              brk      <= 1'b0;
              ext_flag <= 1'b0;
`endif
            end else begin
              strb     <= 1'b1;
              ev.code  <= shreg;
              ev.make  <= brk;
              brk      <= 1'b0;
`ifdef PS2_EXTENDED_EN
              ev.ext   <= ext_flag;
              ext_flag <= 1'b0;
`else
              ev.ext   <= 1'b0;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode.sv
// tb_ps2_scancode: directed PS/2 frame stimulus with an expected-event
// scoreboard; a monitor pops expectations as strb/err pulses appear and
// also checks that outputs hold between strobes.
`timescale 1ns/1ps
module tb_ps2_scancode;
  import ps2_pkg::*;

  localparam int unsigned CLK_KHZ    = 1000;
  localparam int unsigned TIMEOUT_US = 250;
  localparam int          BIT_CYC    = 80;  // 12.5 kHz at a 1 MHz clock
`ifdef PS2_EXTENDED_EN
  localparam logic EXP_EXT = 1'b1;
`else
  localparam logic EXP_EXT = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  always #500 clock = ~clock;

  ps2_scancode_if ev ();

  ps2_scancode #(.CLK_KHZ(CLK_KHZ), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .strb    (ev.strb),
    .make    (ev.make),
    .code    (ev.code),
    .ext     (ev.ext),
    .err     (ev.err)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       make;
    logic       ext;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic push_key(input logic [7:0] c, input logic m, input logic x);
    exp_t e;
    e.is_err = 1'b0; e.code = c; e.make = m; e.ext = x;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.code = 8'h00; e.make = 1'b0; e.ext = 1'b0;
    q.push_back(e);
  endtask

  // Device drives data while the clock is high; the host samples on the fall.
  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_cyc(BIT_CYC / 4);
    ps2_clk = 1'b0;
    wait_cyc(BIT_CYC / 2);
    ps2_clk = 1'b1;
    wait_cyc(BIT_CYC / 4);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    ps2_dat = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
    wait_cyc(20);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strb"}, 32'(ev.strb), 32'd0);
    chk({tag, "_err"},  32'(ev.err),  32'd0);
    chk({tag, "_make"}, 32'(ev.make), 32'd1);
    chk({tag, "_code"}, 32'(ev.code), 32'h00);
    chk({tag, "_ext"},  32'(ev.ext),  32'd0);
    chk({tag, "_fsm"},  32'(dut.state), 32'(ST_IDLE));
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  logic       held_make = 1'b1;
  logic [7:0] held_code = 8'h00;
  logic       held_ext  = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      held_make = 1'b1; held_code = 8'h00; held_ext = 1'b0;
    end else begin
      if (ev.strb || ev.err) begin
        chk("strb_err_excl", 32'(ev.strb & ev.err), 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_event", 32'({ev.strb, ev.err}), 32'd0);
        end else begin
          e = q.pop_front();
          chk("evt_is_err", 32'(ev.err), 32'(e.is_err));
          if (!e.is_err) begin
            chk("evt_code", 32'(ev.code), 32'(e.code));
            chk("evt_make", 32'(ev.make), 32'(e.make));
            chk("evt_ext",  32'(ev.ext),  32'(e.ext));
          end
        end
      end
      if (ev.strb) begin
        held_make = ev.make; held_code = ev.code; held_ext = ev.ext;
      end else begin
        chk("hold_outputs", 32'({ev.make, ev.code, ev.ext}),
            32'({held_make, held_code, held_ext}));
      end
    end
  end

  initial begin
    // Reset values
    wait_cyc(5);
    @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b1;
    wait_cyc(20);

    // Plain make code
    push_key(8'h1C, 1'b0, 1'b0);
    send_ok(8'h1C);

    // Break code
    push_key(8'h1C, 1'b1, 1'b0);
    send_ok(PS2_PFX_BRK);
    send_ok(8'h1C);

    // Extended break
    push_key(8'h75, 1'b1, EXP_EXT);
    send_ok(PS2_PFX_EXT);
    send_ok(PS2_PFX_BRK);
    send_ok(8'h75);

    // Parity error, then recovery
    push_err();
    send_frame(8'h1C, 1'b1, 11);
    wait_cyc(20);
    push_key(8'h1B, 1'b0, 1'b0);
    send_ok(8'h1B);

    // Mid-frame timeout, then recovery
    push_err();
    send_frame(8'h29, 1'b0, 4);
    wait_cyc(400);
    @(negedge clock);
    chk("timeout_fsm_idle", 32'(dut.state), 32'(ST_IDLE));
    push_key(8'h29, 1'b0, 1'b0);
    send_ok(8'h29);

    // Repeated break prefix is idempotent
    push_key(8'h1C, 1'b1, 1'b0);
    send_ok(PS2_PFX_BRK);
    send_ok(PS2_PFX_BRK);
    send_ok(8'h1C);

    // Pause prefix dropped, flags untouched
    push_key(8'h14, 1'b0, 1'b0);
    send_ok(PS2_PFX_PAUSE);
    send_ok(8'h14);

    // Fake shift: suppressed only in the extended build
`ifndef PS2_EXTENDED_EN
    push_key(PS2_FAKE_LSHIFT, 1'b0, 1'b0);
`endif
    push_key(8'h1C, 1'b0, 1'b0);
    send_ok(PS2_PFX_EXT);
    send_ok(PS2_FAKE_LSHIFT);
    send_ok(8'h1C);

    // False start: a single clock with data high produces nothing
    send_bit(1'b1);
    wait_cyc(20);

    // Stop bit low is discarded
    push_err();
    send_frame(8'h33, 1'b0, 10);
    send_bit(1'b0);
    ps2_dat = 1'b1;
    wait_cyc(20);

    // Reset after the 5th data bit, then a clean frame
    send_frame(8'h5A, 1'b0, 6);
    reset = 1'b0;
    wait_cyc(3);
    @(negedge clock);
    chk_reset_outputs("midreset");
    reset = 1'b1;
    wait_cyc(20);
    push_key(8'h5A, 1'b0, 1'b0);
    send_ok(8'h5A);
    wait_cyc(50);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode.md
PS2_SCANCODE -- requirements
Module: ps2_scancode

Interface
REQ-001 SHALL have parameter CLK_KHZ, default 28000, giving the system clock frequency in kHz.
REQ-002 SHALL have parameter TIMEOUT_US, default 250, giving the maximum gap between PS/2 clock falling edges within one frame.
REQ-003 SHALL have port clock, input, 1, the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1, raw PS/2 clock line, asynchronous to clock.
REQ-006 SHALL have port ps2_dat, input, 1, raw PS/2 data line, asynchronous to clock.
REQ-007 SHALL have port strb, output, 1, one-cycle pulse qualifying make, code and ext.
REQ-008 SHALL have port make, output, 1, key state for the matrix: 0 = pressed, 1 = released.
REQ-009 SHALL have port code, output, 8, scancode without prefixes.
REQ-010 SHALL have port ext, output, 1, set when the code was E0-prefixed.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on a discarded frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_dat through two synchronising flops each.
REQ-013 SHALL detect a falling edge only when the synchronised ps2_clk has been high for 4 consecutive cycles and is then low for 4 consecutive cycles, which filters glitches.
REQ-014 SHALL run a frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing one step per detected falling edge.
REQ-015 SHALL, in IDLE, move to DATA only if ps2_dat = 0 at the edge; a 1 (false start) stays in IDLE with no err.
REQ-016 SHALL, in DATA, shift in 8 bits LSB first and count them with a 3-bit counter that wraps from 7 to PARITY.
REQ-017 SHALL check odd parity across the 8 data bits plus the parity bit; the stop bit SHALL be 1.
REQ-018 SHALL, on a parity or stop failure, discard the byte, pulse err, clear the prefix flags and return to IDLE.
REQ-019 SHALL, when not in IDLE and no falling edge occurs for CLK_KHZ*TIMEOUT_US/1000 cycles, return to IDLE, pulse err and clear the prefix flags.
REQ-020 SHALL, for a valid byte F0, set the brk flag without pulsing strb.
REQ-021 SHALL, for a valid byte E0, set the ext flag without pulsing strb.
REQ-022 SHALL drop a valid byte E1 silently and leave the flags unchanged.
REQ-023 SHALL, for any other valid byte, drive code = byte, make = brk and ext = the ext flag, pulse strb, then clear both flags.
REQ-024 SHALL assert strb exactly 1 cycle after the cycle in which the stop-bit edge is detected.
REQ-025 SHALL hold code, make and ext stable until the next strb.
REQ-026 SHALL never assert strb and err in the same cycle.
REQ-027 SHALL treat a repeated F0 or E0 before the code as idempotent.

Reset
REQ-028 SHALL, while reset is low, hold the FSM in IDLE with the counter at 0, brk=0, ext flag=0 and the timeout counter at 0.
REQ-029 SHALL, while reset is low, drive strb=0, err=0, make=1, code=8'h00 and ext=0.
REQ-030 SHALL set the synchroniser flops to 1 on reset.
REQ-031 SHALL, when reset is asserted mid-frame, abandon the frame; the next frame SHALL be received correctly.

Configuration
REQ-032 SHALL implement macro PS2_EXTENDED_EN: when defined, ext reflects E0, and codes E0 12 and E0 59 (fake shifts) are suppressed with no strb.
REQ-033 SHALL, when PS2_EXTENDED_EN is undefined, tie ext to 0 and drop E0 bytes, so E0-prefixed codes are reported as plain codes with no suppression.

Structure
REQ-034 SHALL take from shared package ps2_pkg the constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1 and the FSM state encodings.
REQ-035 SHALL implement the synchroniser and edge filter of REQ-012/013 as sub-module ps2_sync, with outputs for the falling-edge pulse and the synchronised data.

Verification
REQ-036 SHALL cover: frame 1C sent at 12.5 kHz -> one strb with code=1C, make=0, ext=0.
REQ-037 SHALL cover: F0 then 1C -> exactly one strb, with code=1C, make=1.
REQ-038 SHALL cover: E0 F0 75 -> strb with code=75, make=1, ext=1 (macro defined) or ext=0 (macro undefined).
REQ-039 SHALL cover: byte 1C with a wrong parity bit -> err pulse and no strb; a following valid 1B -> strb with code=1B.
REQ-040 SHALL cover: 4 bits then a 300 us gap -> err pulse, FSM in IDLE; the next full 29 frame -> strb with code=29.
REQ-041 SHALL cover: reset asserted after the 5th bit of 5A -> all outputs at reset values; a following 5A -> strb with code=5A, make=0.
